// File: rtl/nibble_serial_addsub_ctrl.sv
// nibble_serial_addsub_ctrl
// Word-wide signed add/subtract sequenced through one 4-bit add/sub slice,
// one nibble per clock, LSB first, with the carry chained between nibbles.
// Handshake: start (taken in IDLE or DONE), busy while running, done pulse.
// Optional build macro: ADDSUB_SATURATE_EN clamps the result on signed
// overflow (default build: result wraps modulo 2^W).
//
// state | meaning
// IDLE  | waiting for start, outputs hold last completion
// RUN   | one nibble per clock through the slice
// DONE  | one-cycle done pulse, start accepted back-to-back

module nibble_serial_addsub_ctrl #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         operator,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         overflow,
    output logic         zero
);

    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic           op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   result_q, result_d;
    logic           carry_out_q, carry_out_d;
    logic           overflow_q, overflow_d;
    logic           zero_q, zero_d;

    logic [3:0]     a_nib;
    logic [3:0]     b_nib;
    logic [3:0]     low_sum;
    logic [4:0]     slice_sum;
    logic           slice_ovf;

    // 4-bit add/sub slice on the current nibble: a + (b ^ op) + carry.
    always_comb begin
        a_nib     = a_q[{idx_q, 2'b00} +: 4];
        b_nib     = b_q[{idx_q, 2'b00} +: 4] ^ {4{op_q}};
        low_sum   = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_q};
        slice_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
        // carry into bit 3 xor carry out of bit 3; only used on the top nibble
        slice_ovf = low_sum[3] ^ slice_sum[4];
    end

    // Next-state and datapath updates for the sequencer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = operator;
                    carry_d = operator;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = slice_sum[3:0];
                carry_d = slice_sum[4];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    carry_out_d = slice_sum[4];
                    overflow_d  = slice_ovf;
                    // flags come from the wrapped result, before any clamp
                    zero_d      = (result_d == '0);
`ifdef ADDSUB_SATURATE_EN
                    if (slice_ovf) begin
                        // on overflow both effective signs equal a's sign
                        result_d = a_q[W-1] ? {1'b1, {(W-1){1'b0}}}
                                            : {1'b0, {(W-1){1'b1}}};
                    end
`endif
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            op_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Testbench for nibble_serial_addsub_ctrl (NIBBLES=4, W=16).
// Expected completions are queued when an op is launched and popped when
// done is observed.

module tb_nibble_serial_addsub_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         operator = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry_out, overflow, zero;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [W-1:0] r;
        logic         co;
        logic         ov;
        logic         z;
    } exp_t;

    exp_t sb[$];

    nibble_serial_addsub_ctrl #(.NIBBLES(NIB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .operator(operator),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    // count every done pulse seen
    always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

    // reference: full-width arithmetic, independent of nibble sequencing
    function automatic exp_t model(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         m;
        logic [W:0]   s;
        logic [W-1:0] ye;
        ye   = op ? ~y : y;
        s    = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, op};
        m.r  = s[W-1:0];
        m.co = s[W];
        m.ov = (x[W-1] == ye[W-1]) && (m.r[W-1] != x[W-1]);
        m.z  = (m.r == '0);
`ifdef ADDSUB_SATURATE_EN
        if (m.ov) m.r = x[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        return m;
    endfunction

    // drive one start cycle from a point just after a rising edge
    task automatic launch(input logic op, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        start    = 1'b1;
        operator = op;
        a        = x;
        b        = y;
        if (push) sb.push_back(model(op, x, y));
        @(posedge clk); #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        operator = 1'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++; $display("FAIL reset_handshake: busy/done=%b required 00", {busy, done});
        end
        n_checks++;
        if (result !== '0) begin
            n_fail++; $display("FAIL reset_result: got %h required 0000", result);
        end
        n_checks++;
        if ({carry_out, overflow, zero} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: co/ov/z=%b required 000", {carry_out, overflow, zero});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ops();
        logic [W-1:0] ta[4] = '{16'h1234, 16'h7FFF, 16'h8000, 16'h0005};
        logic [W-1:0] tb_[4] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0005};
        logic         to[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_t         e;
        int           cyc, bcnt;
        bit           seen;
        for (int i = 0; i < 12; i++) begin
            if (i < 4) launch(to[i], ta[i], tb_[i], 1'b1);
            else       launch(1'($urandom), W'($urandom), W'($urandom), 1'b1);
            seen = 1'b0; bcnt = 0; cyc = 0;
            for (int c = 1; c <= 20 && !seen; c++) begin
                @(negedge clk);
                if (busy === 1'b1) bcnt++;
                if (done === 1'b1) begin seen = 1'b1; cyc = c; end
            end
            n_checks++;
            if (!seen || cyc != NIB + 1) begin
                n_fail++; $display("FAIL op%0d_latency: done at cycle %0d required %0d", i, cyc, NIB + 1);
            end
            n_checks++;
            if (bcnt != NIB) begin
                n_fail++; $display("FAIL op%0d_busy_cycles: got %0d required %0d", i, bcnt, NIB);
            end
            e = sb.pop_front();
            n_checks++;
            if ({result, carry_out, overflow, zero} !== e) begin
                n_fail++; $display("FAIL op%0d_fields: r/co/ov/z=%h/%b/%b/%b required %h/%b/%b/%b",
                                   i, result, carry_out, overflow, zero, e.r, e.co, e.ov, e.z);
            end
            // spec constants for the directed cases, independent of the model
            if (i < 4) begin
                exp_t k;
                case (i)
                    0: k = '{16'h2233, 1'b0, 1'b0, 1'b0};
`ifdef ADDSUB_SATURATE_EN
                    1: k = '{16'h7FFF, 1'b0, 1'b1, 1'b0};
                    2: k = '{16'h8000, 1'b1, 1'b1, 1'b0};
`else
                    1: k = '{16'h8000, 1'b0, 1'b1, 1'b0};
                    2: k = '{16'h7FFF, 1'b1, 1'b1, 1'b0};
`endif
                    default: k = '{16'h0000, 1'b1, 1'b0, 1'b1};
                endcase
                n_checks++;
                if ({result, carry_out, overflow, zero} !== k) begin
                    n_fail++; $display("FAIL op%0d_directed: r/co/ov/z=%h/%b/%b/%b required %h/%b/%b/%b",
                                       i, result, carry_out, overflow, zero, k.r, k.co, k.ov, k.z);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        bit   seen;
        launch(1'b1, 16'h0005, 16'h0005, 1'b1);
        for (int op = 0; op < 2; op++) begin
            seen = 1'b0; cyc = 0;
            for (int c = 1; c <= 20 && !seen; c++) begin
                @(negedge clk);
                if (done === 1'b1) begin seen = 1'b1; cyc = c; end
            end
            n_checks++;
            if (!seen || cyc != NIB + 1) begin
                n_fail++; $display("FAIL b2b%0d_latency: done at cycle %0d required %0d", op, cyc, NIB + 1);
            end
            e = sb.pop_front();
            n_checks++;
            if ({result, carry_out, overflow, zero} !== e) begin
                n_fail++; $display("FAIL b2b%0d_fields: r/co/ov/z=%h/%b/%b/%b required %h/%b/%b/%b",
                                   op, result, carry_out, overflow, zero, e.r, e.co, e.ov, e.z);
            end
            if (op == 0) begin
                // start asserted during the DONE cycle
                start = 1'b1; operator = 1'b1; a = 16'h0000; b = 16'h0001;
                sb.push_back(model(1'b1, 16'h0000, 16'h0001));
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        n_checks++;
        if ({result, carry_out, zero} !== {16'hFFFF, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL b2b_directed: r/co/z=%h/%b/%b required ffff/0/0", result, carry_out, zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int   cyc, bcnt, d0;
        bit   seen;
        d0 = done_cnt;
        launch(1'b0, 16'h1234, 16'h0FFF, 1'b1);
        seen = 1'b0; cyc = 0; bcnt = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            if (c == 2 || c == 3) begin
                start = 1'b1; operator = 1'b1; a = 16'h4444 + 16'(c); b = 16'h1111;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin seen = 1'b1; cyc = c; end
            else begin @(posedge clk); #1; end
        end
        start = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (!seen || cyc != NIB + 1) begin
            n_fail++; $display("FAIL ignore_latency: done at cycle %0d required %0d", cyc, NIB + 1);
        end
        n_checks++;
        if (bcnt != NIB) begin
            n_fail++; $display("FAIL ignore_busy_cycles: got %0d required %0d", bcnt, NIB);
        end
        n_checks++;
        if (done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL ignore_done_count: got %0d required 1", done_cnt - d0);
        end
        e = sb.pop_front();
        n_checks++;
        if ({result, carry_out, overflow, zero} !== e) begin
            n_fail++; $display("FAIL ignore_fields: r/co/ov/z=%h/%b/%b/%b required %h/%b/%b/%b",
                               result, carry_out, overflow, zero, e.r, e.co, e.ov, e.z);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        int   cyc, d0;
        bit   seen;
        // leave carry_out/overflow set so the abort has something to clear
        launch(1'b1, 16'h8000, 16'h0001, 1'b1);
        repeat (NIB + 1) @(negedge clk);
        void'(sb.pop_front());
        @(posedge clk); #1;
        launch(1'b0, 16'h1234, 16'h0FFF, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        d0 = done_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if ({busy, done, result, carry_out, overflow, zero} !== '0) begin
            n_fail++; $display("FAIL abort_outputs: busy/done/r/co/ov/z=%b/%b/%h/%b/%b/%b required all 0",
                               busy, done, result, carry_out, overflow, zero);
        end
        repeat (8) @(negedge clk);
        n_checks++;
        if (done_cnt != d0) begin
            n_fail++; $display("FAIL abort_no_done: %0d done pulses required 0", done_cnt - d0);
        end
        @(posedge clk); #1;
        launch(1'b0, 16'h1234, 16'h0FFF, 1'b1);
        seen = 1'b0; cyc = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin seen = 1'b1; cyc = c; end
        end
        n_checks++;
        if (!seen || cyc != NIB + 1) begin
            n_fail++; $display("FAIL after_abort_latency: done at cycle %0d required %0d", cyc, NIB + 1);
        end
        e = sb.pop_front();
        n_checks++;
        if ({result, carry_out, overflow, zero} !== e) begin
            n_fail++; $display("FAIL after_abort_fields: r/co/ov/z=%h/%b/%b/%b required %h/%b/%b/%b",
                               result, carry_out, overflow, zero, e.r, e.co, e.ov, e.z);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_ops();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_run();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
